// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Packet-aware round-robin arbiter sharing one AXI4-Stream channel between INPUTS requesters.
// A grant is held from the first beat through tlast; the output stage is a single register slice.
module logic_axi4_stream_packet_arbiter #(
  parameter int INPUTS      = 4,
  parameter int TDATA_BYTES = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int USE_TLAST   = 1,
  parameter int IDX_WIDTH   = $clog2(INPUTS)
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [INPUTS-1:0]                   rx_tvalid,
  output logic [INPUTS-1:0]                   rx_tready,
  input  logic [INPUTS*TDATA_BYTES*8-1:0]     rx_tdata,
  input  logic [INPUTS-1:0]                   rx_tlast,
  input  logic [INPUTS*TUSER_WIDTH-1:0]       rx_tuser,
  output logic                                tx_tvalid,
  input  logic                                tx_tready,
  output logic [TDATA_BYTES*8-1:0]            tx_tdata,
  output logic                                tx_tlast,
  output logic [TUSER_WIDTH-1:0]              tx_tuser,
  output logic [IDX_WIDTH-1:0]                tx_tid
);

  localparam int DW = TDATA_BYTES * 8;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e               state_q, state_d;
  // Index of the requester currently (or most recently) granted; doubles as the
  // round-robin pointer, so it only moves when a new grant is made.
  logic [IDX_WIDTH-1:0] grant_q, grant_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [DW-1:0]        tx_data_q, tx_data_d;
  logic                 tx_last_q, tx_last_d;
  logic [TUSER_WIDTH-1:0] tx_user_q, tx_user_d;
  logic [IDX_WIDTH-1:0] tx_tid_q, tx_tid_d;

  logic                 found_hi, found_lo;
  logic [IDX_WIDTH-1:0] pick_hi, pick_lo, rr_pick;
  logic [DW-1:0]        sel_data;
  logic                 sel_last;
  logic [TUSER_WIDTH-1:0] sel_user;
  logic                 slot_free;
  logic                 accept;

  // Round-robin search: first valid above the pointer wins, otherwise first valid
  // at or below it. Iterating downward lets the lowest index overwrite higher ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = INPUTS - 1; i >= 0; i--) begin
      if (rx_tvalid[i] && (i > int'(grant_q))) begin
        found_hi = 1'b1;
        pick_hi  = IDX_WIDTH'(i);
      end
      if (rx_tvalid[i] && (i <= int'(grant_q))) begin
        found_lo = 1'b1;
        pick_lo  = IDX_WIDTH'(i);
      end
    end
    rr_pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_user = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (grant_q == IDX_WIDTH'(i)) begin
        sel_data = rx_tdata[i*DW +: DW];
        sel_last = (USE_TLAST != 0) ? rx_tlast[i] : 1'b1;
        sel_user = rx_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
      end
    end
  end

  assign slot_free = !tx_valid_q || tx_tready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rx_tready  = '0;
    accept     = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    tx_user_d  = tx_user_q;
    tx_tid_d   = tx_tid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|rx_tvalid) begin
          grant_d = rr_pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        rx_tready[grant_q] = slot_free;
        accept             = rx_tvalid[grant_q] && slot_free;
        if (accept && sel_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new beat overwrites the slot in the same cycle the old one drains.
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = sel_data;
      tx_last_d  = sel_last;
      tx_user_d  = sel_user;
      tx_tid_d   = grant_q;
    end else if (tx_tready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (areset) begin
      state_q    <= ST_IDLE;
      grant_q    <= IDX_WIDTH'(INPUTS - 1);
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
      tx_user_q  <= '0;
      tx_tid_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
      tx_user_q  <= tx_user_d;
      tx_tid_q   <= tx_tid_d;
    end
  end

  assign tx_tvalid = tx_valid_q;
  assign tx_tdata  = tx_data_q;
  assign tx_tlast  = tx_last_q;
  assign tx_tuser  = tx_user_q;
  assign tx_tid    = tx_tid_q;

endmodule

// File: tb/tb_logic_axi4_stream_packet_arbiter.sv
// Bench for logic_axi4_stream_packet_arbiter: packet-level round-robin reference model
// plus per-scenario checks on ordering, gaps, stalls and reset.
module tb_logic_axi4_stream_packet_arbiter;

  localparam int INPUTS = 4;
  localparam int MAXB   = 64;

  logic                aclk = 1'b0;
  logic                areset;
  logic [INPUTS-1:0]   rx_tvalid;
  logic [INPUTS-1:0]   rx_tready;
  logic [INPUTS*8-1:0] rx_tdata;
  logic [INPUTS-1:0]   rx_tlast;
  logic [INPUTS-1:0]   rx_tuser;
  logic                tx_tvalid;
  logic                tx_tready;
  logic [7:0]          tx_tdata;
  logic                tx_tlast;
  logic [0:0]          tx_tuser;
  logic [1:0]          tx_tid;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic [1:0] tid;
  } beat_t;

  typedef struct packed {
    int cyc;
    int req;
    int idx;
  } hs_t;

  beat_t src_mem [INPUTS][MAXB];
  int    src_len [INPUTS];
  int    src_pos [INPUTS];
  int    hold_cnt[INPUTS];
  beat_t exp_q[$];
  beat_t obs_q[$];
  hs_t   hs_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  logic_axi4_stream_packet_arbiter #(
    .INPUTS(INPUTS), .TDATA_BYTES(1), .TUSER_WIDTH(1), .USE_TLAST(1)
  ) dut (
    .aclk(aclk), .areset(areset),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tlast(tx_tlast), .tx_tuser(tx_tuser), .tx_tid(tx_tid)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic clear_sources();
    for (int i = 0; i < INPUTS; i++) begin
      src_len[i]  = 0;
      src_pos[i]  = 0;
      hold_cnt[i] = 0;
    end
  endtask

  task automatic add_packet(input int req, input int len, input logic [7:0] base);
    for (int b = 0; b < len; b++) begin
      src_mem[req][src_len[req]] = '{data: 8'(base + 8'(b)), last: (b == len - 1),
                                     user: 1'($urandom), tid: 2'(req)};
      src_len[req]++;
    end
  endtask

  // Packet-level model: after reset the pointer sits at INPUTS-1; each packet goes to
  // the next requester (cyclically above the pointer) that still has data queued.
  task automatic build_expected();
    int pos[INPUTS];
    int ptr;
    int nxt;
    ptr = INPUTS - 1;
    exp_q.delete();
    for (int i = 0; i < INPUTS; i++) pos[i] = 0;
    forever begin
      nxt = -1;
      for (int k = 1; k <= INPUTS; k++) begin
        if (nxt < 0 && pos[(ptr + k) % INPUTS] < src_len[(ptr + k) % INPUTS])
          nxt = (ptr + k) % INPUTS;
      end
      if (nxt < 0) break;
      forever begin
        exp_q.push_back(src_mem[nxt][pos[nxt]]);
        pos[nxt]++;
        if (src_mem[nxt][pos[nxt] - 1].last) break;
      end
      ptr = nxt;
    end
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    areset    = 1'b1;
    rx_tvalid = '0;
    tx_tready = 1'b0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  // Drives queued packets, monitors both sides and scoreboards every output beat.
  task automatic run_traffic(input int ready_pct, input int stall_start, input int stall_len,
                             input int gap_pct, input int fg_req, input int fg_after,
                             input int fg_len, input int max_cycles);
    int    n;
    int    ei;
    bit    prev_stall;
    bit    all_sent;
    beat_t prev_beat;
    beat_t cur;
    beat_t b;
    n = 0; ei = 0; prev_stall = 0; prev_beat = '0;
    obs_q.delete();
    hs_q.delete();
    build_expected();
    forever begin
      @(negedge aclk);
      all_sent = 1'b1;
      for (int i = 0; i < INPUTS; i++) if (src_pos[i] < src_len[i]) all_sent = 1'b0;
      if (all_sent && ei == exp_q.size() && !tx_tvalid) break;
      if (n >= max_cycles) begin
        n_cmp++; n_bad++;
        $display("FAIL stream_timeout: got %0d beats out, required %0d", ei, exp_q.size());
        break;
      end
      cur = '{data: tx_tdata, last: tx_tlast, user: tx_tuser[0], tid: tx_tid};
      if (prev_stall) begin
        n_cmp++;
        if ({tx_tvalid, cur} !== {1'b1, prev_beat}) begin
          n_bad++;
          $display("FAIL stall_hold: got valid=%0b beat=%h, required valid=1 beat=%h",
                   tx_tvalid, cur, prev_beat);
        end
      end
      if (n >= stall_start && n < stall_start + stall_len) tx_tready = 1'b0;
      else tx_tready = (int'($urandom_range(0, 99)) < ready_pct);
      for (int i = 0; i < INPUTS; i++) begin
        if (hold_cnt[i] > 0) begin
          rx_tvalid[i] = 1'b0;
          hold_cnt[i]--;
        end else if (src_pos[i] < src_len[i]) begin
          rx_tvalid[i]       = 1'b1;
          rx_tdata[i*8 +: 8] = src_mem[i][src_pos[i]].data;
          rx_tlast[i]        = src_mem[i][src_pos[i]].last;
          rx_tuser[i]        = src_mem[i][src_pos[i]].user;
        end else begin
          rx_tvalid[i] = 1'b0;
        end
      end
      #1;
      n_cmp++;
      if (!$onehot0(rx_tready)) begin
        n_bad++;
        $display("FAIL rx_tready_onehot: got %b, required one-hot or zero", rx_tready);
      end
      if (tx_tvalid && !tx_tready) begin
        n_cmp++;
        if (rx_tready !== '0) begin
          n_bad++;
          $display("FAIL stall_rx_tready: got %b, required 0000", rx_tready);
        end
      end
      if (tx_tvalid && tx_tready) begin
        n_cmp++;
        if (ei >= exp_q.size()) begin
          n_bad++;
          $display("FAIL extra_beat: got %h, required no further beat", cur);
        end else begin
          if (cur !== exp_q[ei]) begin
            n_bad++;
            $display("FAIL beat_%0d: got %h, required %h", ei, cur, exp_q[ei]);
          end
          ei++;
        end
        obs_q.push_back(cur);
      end
      for (int i = 0; i < INPUTS; i++) begin
        if (rx_tvalid[i] && rx_tready[i]) begin
          hs_q.push_back('{cyc: n, req: i, idx: src_pos[i]});
          b = src_mem[i][src_pos[i]];
          if (!b.last) begin
            if (i == fg_req && src_pos[i] == fg_after) hold_cnt[i] = fg_len;
            else if (int'($urandom_range(0, 99)) < gap_pct) hold_cnt[i] = int'($urandom_range(1, 2));
          end
          src_pos[i]++;
        end
      end
      prev_stall = tx_tvalid && !tx_tready;
      prev_beat  = cur;
      n++;
    end
    n_cmp++;
    if (ei != exp_q.size()) begin
      n_bad++;
      $display("FAIL stream_count: got %0d beats, required %0d", ei, exp_q.size());
    end
    rx_tvalid = '0;
  endtask

  task automatic test_reset();
    areset    = 1'b1;
    rx_tvalid = '1;
    rx_tdata  = 32'hC3B2_A190;
    rx_tlast  = '1;
    rx_tuser  = '1;
    tx_tready = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      n_cmp += 3;
      if (rx_tready !== '0) begin
        n_bad++; $display("FAIL reset_rx_tready: got %b, required 0000", rx_tready);
      end
      if (tx_tvalid !== 1'b0) begin
        n_bad++; $display("FAIL reset_tx_tvalid: got %b, required 0", tx_tvalid);
      end
      if (tx_tid !== 2'd0) begin
        n_bad++; $display("FAIL reset_tx_tid: got %0d, required 0", tx_tid);
      end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_data[6] = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
    int         exp_tid[6]  = '{0, 0, 0, 2, 2, 2};
    apply_reset();
    clear_sources();
    add_packet(0, 3, 8'hA0);
    add_packet(2, 3, 8'hC0);
    run_traffic(100, 0, 0, 0, -1, 0, 0, 200);
    n_cmp++;
    if (obs_q.size() != 6) begin
      n_bad++; $display("FAIL fair_count: got %0d, required 6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (obs_q[i].data !== exp_data[i] || int'(obs_q[i].tid) != exp_tid[i]) begin
          n_bad++;
          $display("FAIL fair_beat_%0d: got %h/tid%0d, required %h/tid%0d",
                   i, obs_q[i].data, obs_q[i].tid, exp_data[i], exp_tid[i]);
        end
      end
    end
    n_cmp++;
    if (hs_q.size() != 6) begin
      n_bad++; $display("FAIL fair_hs_count: got %0d, required 6", hs_q.size());
    end else if (hs_q[3].cyc - hs_q[2].cyc != 2) begin
      n_bad++; $display("FAIL fair_bubble: got gap %0d, required 2", hs_q[3].cyc - hs_q[2].cyc);
    end
  endtask

  task automatic test_atomicity();
    int last1;
    int first3;
    apply_reset();
    clear_sources();
    add_packet(1, 4, 8'h10);
    add_packet(3, 3, 8'h30);
    run_traffic(100, 0, 0, 0, 1, 1, 2, 200);
    last1 = -1; first3 = -1;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].tid == 2'd1 && obs_q[i].last) last1 = i;
      if (obs_q[i].tid == 2'd3 && first3 < 0) first3 = i;
    end
    n_cmp++;
    if (last1 < 0 || first3 <= last1) begin
      n_bad++; $display("FAIL atomic_order: got tid3 at %0d, tid1 last at %0d", first3, last1);
    end
    n_cmp++;
    if (hs_q.size() < 3) begin
      n_bad++; $display("FAIL atomic_hs_count: got %0d, required 7", hs_q.size());
    end else if (hs_q[2].cyc - hs_q[1].cyc != 3 || hs_q[2].req != 1) begin
      n_bad++;
      $display("FAIL atomic_gap: got req%0d after %0d cycles, required req1 after 3",
               hs_q[2].req, hs_q[2].cyc - hs_q[1].cyc);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    clear_sources();
    add_packet(0, 8, 8'h50);
    run_traffic(100, 5, 5, 0, -1, 0, 0, 200);
    n_cmp++;
    if (hs_q.size() != 8) begin
      n_bad++; $display("FAIL bp_hs_count: got %0d, required 8", hs_q.size());
    end else if (hs_q[7].cyc - hs_q[0].cyc != 12) begin
      n_bad++; $display("FAIL bp_rate: got span %0d, required 12", hs_q[7].cyc - hs_q[0].cyc);
    end
  endtask

  task automatic test_rr_wrap();
    int exp_tid[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    apply_reset();
    clear_sources();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < INPUTS; r++) add_packet(r, 1, 8'(r * 16 + k));
    run_traffic(100, 0, 0, 0, -1, 0, 0, 200);
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_bad++; $display("FAIL rr_count: got %0d, required 8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (int'(obs_q[i].tid) != exp_tid[i]) begin
          n_bad++; $display("FAIL rr_tid_%0d: got %0d, required %0d", i, obs_q[i].tid, exp_tid[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int total;
    for (int round = 0; round < 4; round++) begin
      apply_reset();
      clear_sources();
      total = 0;
      for (int r = 0; r < INPUTS; r++) begin
        for (int p = int'($urandom_range(0, 3)); p > 0; p--) begin
          add_packet(r, int'($urandom_range(1, 4)), 8'($urandom));
          total++;
        end
      end
      if (total == 0) add_packet(int'($urandom_range(0, 3)), 2, 8'h77);
      run_traffic(60, 0, 0, 30, -1, 0, 0, 2000);
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    apply_reset();
    tx_tready = 1'b1;
    hs = 0;
    for (int n = 0; n < 20 && hs < 2; n++) begin
      @(negedge aclk);
      rx_tvalid          = 4'b0100;
      rx_tdata[16 +: 8]  = 8'(8'h20 + hs);
      rx_tlast[2]        = (hs == 4);
      #1;
      if (rx_tready[2]) hs++;
    end
    n_cmp++;
    if (hs != 2) begin
      n_bad++; $display("FAIL rstmid_start: got %0d beats accepted, required 2", hs);
    end
    @(negedge aclk);
    areset            = 1'b1;
    rx_tdata[16 +: 8] = 8'h22;
    rx_tvalid         = 4'b0101;
    rx_tdata[0 +: 8]  = 8'h0F;
    rx_tlast          = 4'b0001;
    @(negedge aclk);
    n_cmp += 3;
    if (tx_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_tvalid: got %b, required 0", tx_tvalid);
    end
    if (rx_tready !== '0) begin
      n_bad++; $display("FAIL rstmid_rx_tready: got %b, required 0000", rx_tready);
    end
    if (tx_tid !== 2'd0 || tx_tdata !== 8'h00) begin
      n_bad++; $display("FAIL rstmid_payload: got tid%0d data %h, required tid0 data 00", tx_tid, tx_tdata);
    end
    areset = 1'b0;
    @(negedge aclk);
    #1;
    n_cmp++;
    if (rx_tready !== 4'b0001) begin
      n_bad++; $display("FAIL rstmid_grant: got %b, required 0001", rx_tready);
    end
    @(negedge aclk);
    rx_tvalid[0] = 1'b0;
    n_cmp++;
    if ({tx_tvalid, tx_tid, tx_tdata, tx_tlast} !== {1'b1, 2'd0, 8'h0F, 1'b1}) begin
      n_bad++;
      $display("FAIL rstmid_first_beat: got v%b tid%0d %h last%b, required v1 tid0 0f last1",
               tx_tvalid, tx_tid, tx_tdata, tx_tlast);
    end
    rx_tvalid = '0;
  endtask

  initial begin
    areset    = 1'b1;
    rx_tvalid = '0;
    rx_tdata  = '0;
    rx_tlast  = '0;
    rx_tuser  = '0;
    tx_tready = 1'b0;
    test_reset();
    test_fairness();
    test_atomicity();
    test_backpressure();
    test_rr_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
